// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and fetch sequencing stage for the
// single-cycle MIPS core. It produces the fetch address and applies stall,
// branch, jump and jump-register redirects. Fetch stops when the halt
// instruction is presented on an advancing cycle.
//
// Optional feature macro: FETCH_PERF_EN. When it is defined, the fetch and
// stall performance counters are built. When it is undefined, both counter
// ports read as zero and no counter flops exist.
//
// Ports:
//   clk            in   system clock, all state on the rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold pc this cycle; redirects are ignored
//   branch_taken   in   take the PC-relative branch
//   branch_offset  in   signed word offset, relative to pc+4
//   jump           in   take the J-format jump
//   jump_target    in   J-format 26-bit target index
//   jump_reg       in   take the register jump
//   jr_target      in   register jump address
//   instr_in       in   instruction word at the current pc
//   pc             out  current fetch address
//   pc_plus4       out  pc + 4, combinational, wraps mod 2^32
//   valid          out  pc/instr_in pair is a live instruction
//   halted         out  fetch stopped on the halt instruction
//   addr_err       out  one-cycle pulse after accepting a misaligned jr_target
//   fetch_count    out  advancing cycles, including the halting one
//   stall_count    out  RUN cycles with stall asserted
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted,
    output logic        addr_err,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        r_addr_err;
    logic        w_next_addr_err;
    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_disp;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_advance     = (r_state == ST_RUN) && !stall;
    // Word offset scaled to a byte displacement; the sum wraps mod 2^32.
    assign w_branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_addr_err <= w_next_addr_err;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_addr_err = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_advance) begin
                    // The halt instruction wins over any redirect in the same
                    // cycle, and pc keeps pointing at it.
                    if (instr_in == HALT_INSTR) begin
                        w_next_state = ST_HALT;
                    end else if (jump_reg) begin
                        w_next_pc       = {jr_target[31:2], 2'b00};
                        w_next_addr_err = |jr_target[1:0];
                    end else if (jump) begin
                        w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
                    end else if (branch_taken) begin
                        w_next_pc = w_pc_plus4 + w_branch_disp;
                    end else begin
                        w_next_pc = w_pc_plus4;
                    end
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_BOOT;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Counting is gated on RUN, so both counters freeze in BOOT and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_advance) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if ((r_state == ST_RUN) && stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    assign fetch_count = 32'h0;
    assign stall_count = 32'h0;
`endif

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign valid    = (r_state == ST_RUN);
    assign halted   = (r_state == ST_HALT);
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. It covers sequential fetch, stall,
// branches, jump priority, misaligned jr_target, address wrap, halt and
// reset out of HALT. A small control model predicts the performance counters.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;
    logic        addr_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int n_checks;
    int n_errors;

    // Control model: 0 = BOOT, 1 = RUN, 2 = HALT.
    int          m_state;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'h0000_000C;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .instr_in      (instr_in),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .valid         (valid),
        .halted        (halted),
        .addr_err      (addr_err),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef FETCH_PERF_EN
        chk({tag, " fetch_count"}, fetch_count, m_fetch);
        chk({tag, " stall_count"}, stall_count, m_stall);
`else
        chk({tag, " fetch_count"}, fetch_count, 32'h0);
        chk({tag, " stall_count"}, stall_count, 32'h0);
`endif
    endtask

    // Updates the control model from the inputs about to be sampled, then
    // advances one clock and settles 1 time unit past the edge.
    task automatic step();
        if (reset) begin
            m_state = 0;
            m_fetch = 32'd0;
            m_stall = 32'd0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (!stall) begin
                        m_fetch = m_fetch + 32'd1;
                        if (instr_in == HALT) m_state = 2;
                    end else begin
                        m_stall = m_stall + 32'd1;
                    end
                end
                default: m_state = 2;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        jump_reg      = 1'b0;
        jr_target     = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_state  = 0;
        m_fetch  = 32'd0;
        m_stall  = 32'd0;
        reset    = 1'b1;
        instr_in = NOP;
        clear_redirects();

        // Reset state
        step();
        chk("reset pc", pc, 32'h0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset addr_err", {31'd0, addr_err}, 32'd0);
        chk_counters("reset");

        // BOOT -> RUN leaves pc untouched
        reset = 1'b0;
        step();
        chk("boot pc", pc, 32'h0);
        chk("boot valid", {31'd0, valid}, 32'd1);
        chk("boot pc_plus4", pc_plus4, 32'h4);

        // Sequential fetch
        step();
        chk("seq pc 4", pc, 32'h4);
        step();
        chk("seq pc 8", pc, 32'h8);

        // Stall with a pending branch: held, branch not taken
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall hold pc", pc, 32'h8);
        end
        clear_redirects();
        step();
        chk("stall release pc", pc, 32'hC);
        chk_counters("after stall");
        step();
        chk("seq pc 10", pc, 32'h10);

        // Jump to 0x20, then a backward branch, then a forward branch
        jump        = 1'b1;
        jump_target = 26'h8;
        step();
        chk("jump to 0x20", pc, 32'h20);
        clear_redirects();
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFC;
        step();
        chk("branch back", pc, 32'h14);
        branch_offset = 16'h0003;
        step();
        chk("branch fwd", pc, 32'h24);

        // Priority: jump_reg beats jump beats branch
        clear_redirects();
        jump        = 1'b1;
        jump_target = 26'h10;
        step();
        chk("jump to 0x40", pc, 32'h40);
        jump_reg     = 1'b1;
        jr_target    = 32'h100;
        branch_taken = 1'b1;
        branch_offset = 16'h0005;
        step();
        chk("priority jr", pc, 32'h100);
        chk("aligned jr addr_err", {31'd0, addr_err}, 32'd0);
        clear_redirects();
        jump        = 1'b1;
        jump_target = 26'h10;
        branch_taken = 1'b1;
        step();
        chk("priority jump", pc, 32'h40);

        // Misaligned jr_target: low bits forced, one-cycle addr_err
        clear_redirects();
        jump_reg  = 1'b1;
        jr_target = 32'h103;
        step();
        chk("misaligned jr pc", pc, 32'h100);
        chk("misaligned jr addr_err", {31'd0, addr_err}, 32'd1);
        clear_redirects();
        step();
        chk("after jr pc", pc, 32'h104);
        chk("addr_err one cycle", {31'd0, addr_err}, 32'd0);

        // Ignored misaligned jr during stall: no pulse
        stall     = 1'b1;
        jump_reg  = 1'b1;
        jr_target = 32'h103;
        step();
        chk("stalled jr pc", pc, 32'h104);
        chk("stalled jr addr_err", {31'd0, addr_err}, 32'd0);

        // Wrap at the top of the address space
        clear_redirects();
        jump_reg  = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        step();
        chk("top pc", pc, 32'hFFFF_FFFC);
        chk("top pc_plus4 wrap", pc_plus4, 32'h0);
        clear_redirects();
        step();
        chk("pc wrap", pc, 32'h0);
        branch_taken  = 1'b1;
        branch_offset = 16'hFFFC;
        step();
        chk("negative branch wrap", pc, 32'hFFFF_FFF4);

        // Halt: stalled halt instruction does nothing until it advances
        clear_redirects();
        jump        = 1'b1;
        jump_target = 26'hC;
        step();
        chk("jump to 0x30", pc, {4'hF, 28'h30});
        jump_reg  = 1'b1;
        jr_target = 32'h30;
        jump      = 1'b0;
        step();
        chk("jr to 0x30", pc, 32'h30);
        clear_redirects();
        instr_in = HALT;
        stall    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stalled halt pc", pc, 32'h30);
            chk("stalled halt halted", {31'd0, halted}, 32'd0);
            chk("stalled halt valid", {31'd0, valid}, 32'd1);
        end
        stall       = 1'b0;
        jump        = 1'b1;
        jump_target = 26'h40;
        step();
        chk("halt pc", pc, 32'h30);
        chk("halt halted", {31'd0, halted}, 32'd1);
        chk("halt valid", {31'd0, valid}, 32'd0);
        chk_counters("at halt");

        // HALT is sticky and ignores every input
        instr_in  = NOP;
        jump_reg  = 1'b1;
        jr_target = 32'h203;
        branch_taken = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            step();
            chk("halted pc frozen", pc, 32'h30);
            chk("halted addr_err", {31'd0, addr_err}, 32'd0);
            chk("halted sticky", {31'd0, halted}, 32'd1);
        end
        chk_counters("halt frozen");

        // Reset out of HALT, with a redirect in flight
        reset = 1'b1;
        step();
        chk("rst halt pc", pc, 32'h0);
        chk("rst halt halted", {31'd0, halted}, 32'd0);
        chk("rst halt valid", {31'd0, valid}, 32'd0);
        chk_counters("rst halt");
        reset = 1'b0;
        clear_redirects();
        step();
        chk("reboot pc", pc, 32'h0);
        chk("reboot valid", {31'd0, valid}, 32'd1);
        step();
        chk("reboot seq pc", pc, 32'h4);
        chk_counters("reboot");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage that sits directly upstream of the single-cycle MIPS core `main`.
- It generates the `pc` that `main` consumes, replacing free-running `pc + 4` stimulus.
- Adds stall, branch, jump and jump-register redirects, and halt detection on a terminating instruction.
- Instruction memory is external: `pc` drives the address; the addressed word returns combinationally on `instr_in`.

Parameters:
- RESET_PC, 32'h0000_0000: pc value loaded on reset; low 2 bits must be 0.
- HALT_INSTR, 32'h0000_000C: instruction encoding (syscall) that halts fetch.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold pc this cycle.
- branch_taken  in  1  take PC-relative branch.
- branch_offset  in  16  signed word offset, relative to pc+4.
- jump  in  1  take J-format jump.
- jump_target  in  26  J-format target index.
- jump_reg  in  1  take register jump.
- jr_target  in  32  register jump address.
- instr_in  in  32  instruction word at current pc.
- pc  out  32  current fetch address, to `main` and imem.
- pc_plus4  out  32  pc + 4, combinational, wraps mod 2^32.
- valid  out  1  pc/instr_in pair is a live instruction.
- halted  out  1  fetch stopped on HALT_INSTR.
- addr_err  out  1  one-cycle pulse: misaligned jr_target was accepted.
- fetch_count  out  32  retired fetches (see Optional Feature).
- stall_count  out  32  stalled live cycles (see Optional Feature).

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous, active-high, sampled on the rising edge, and overrides everything else.
- Reset values: pc=RESET_PC, valid=0, halted=0, addr_err=0, counters=0, state=BOOT.
- FSM states: BOOT, RUN, HALT.
  - BOOT → RUN unconditionally on the next edge. pc is not changed. valid=1 from the RUN cycle onward.
- Advance condition in RUN: a cycle "advances" when state==RUN and stall==0.
- Next-pc priority when advancing:
  1. jump_reg: {jr_target[31:2],2'b00}.
  2. jump: {pc_plus4[31:28], jump_target, 2'b00}.
  3. branch_taken: pc_plus4 + (sign-extended branch_offset << 2).
  4. Otherwise: pc_plus4.
- Address arithmetic is mod 2^32 throughout: 32'hFFFF_FFFC + 4 = 0, and negative offsets below 0 wrap.
- stall=1 in RUN: pc held and all redirect inputs ignored. Redirects are not queued; the source must hold them until accepted.
- Halt: if instr_in==HALT_INSTR on an advancing cycle, at the edge state→HALT, halted=1, valid=0.
  - pc holds the halt instruction's address.
  - Redirects in that same cycle are ignored.
- HALT is sticky: only reset exits it. All inputs are ignored; pc, halted and counters are frozen.
- If a halt instruction is presented while stall=1, there is no halt until the cycle it advances.
- addr_err:
  - Pulses for exactly the one cycle after accepting a jump_reg with jr_target[1:0]!=0.
  - Target bits [1:0] are still forced to 0.
  - No pulse when jump_reg is ignored (stall, BOOT, HALT).
- Reset mid-operation, in any state: the next cycle is BOOT with reset values. An in-flight redirect is discarded.
- No combinational path from instr_in to pc. pc_plus4 is combinational from pc only.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - fetch_count increments on every advancing cycle, including the halting one.
  - stall_count increments on every RUN cycle with stall=1.
  - Both are 32-bit, wrap to 0 at overflow, are cleared by reset and frozen in HALT.
- When undefined: both ports tied to 32'h0 and no counter flops are generated. All other behaviour is identical.

Test Plan:
- Sequential fetch: reset 1 cycle, instr_in=NOP, no redirects for 5 edges after BOOT → pc sequence 0,0(BOOT),4,8,12,16; valid=0 in BOOT, 1 afterwards.
- Branch backward: at pc=0x20, branch_taken=1, offset=16'hFFFC → next pc=0x14. Forward offset 3 at pc=0x14 → 0x24.
- Priority and jump:
  - At pc=0x40, jump_reg=1 (jr_target=0x100), jump=1 (target=0x10) and branch_taken=1 → pc=0x100.
  - Next cycle jump only with target 26'h10 → pc=0x40.
  - jr_target=0x103 accepted → pc=0x100, addr_err=1 for exactly one cycle.
- Stall:
  - Assert stall 3 cycles at pc=0x8 with branch_taken=1 → pc stays 0x8, branch not taken.
  - Release stall with branch deasserted → pc=0xC.
  - With FETCH_PERF_EN: stall_count=3.
- Halt: instr_in=32'h0000_000C at pc=0x30 with stall=1 for 2 cycles → no halt. On release → halted=1, valid=0, pc=0x30; further redirects and 10 clocks leave pc=0x30.
- Reset/wrap: pc forced via jr_target=0xFFFF_FFFC → next pc=0x0. Assert reset while in HALT → BOOT, pc=RESET_PC, halted=0, counters=0.
